// File: rtl/button_debouncer_if.sv
// button_debouncer_if: CE/raw-button inputs and debounced level/strobe outputs.
// The master modport drives the button inputs. The slave modport is the debouncer.
// O_REPEAT is present only when BUTTON_DEBOUNCER_REPEAT_EN is defined.
interface button_debouncer_if #(
   parameter int P_CH = 4
);
   logic            I_CE;
   logic [P_CH-1:0] I_BTN;
   logic [P_CH-1:0] O_LEVEL;
   logic [P_CH-1:0] O_PRESS;
   logic [P_CH-1:0] O_RELEASE;
`ifdef BUTTON_DEBOUNCER_REPEAT_EN
   logic [P_CH-1:0] O_REPEAT;
`endif

   modport master (
      output I_CE, I_BTN,
`ifdef BUTTON_DEBOUNCER_REPEAT_EN
      input  O_REPEAT,
`endif
      input  O_LEVEL, O_PRESS, O_RELEASE
   );

   modport slave (
      input  I_CE, I_BTN,
`ifdef BUTTON_DEBOUNCER_REPEAT_EN
      output O_REPEAT,
`endif
      output O_LEVEL, O_PRESS, O_RELEASE
   );
endinterface

// File: rtl/button_debouncer.sv
// button_debouncer: multi-channel debouncer with a 2-FF synchroniser and a CE-sampled stable-count filter.
// Latency: 2 I_CLK of synchronisation, then acceptance on the P_STABLE-th CE sample at the new value; strobes last 1 I_CLK.
// Backpressure: none. Outputs are free-running registered levels and strobes. Optional auto-repeat: BUTTON_DEBOUNCER_REPEAT_EN.
module button_debouncer #(
   parameter int   P_CH         = 4,
   parameter int   P_STABLE     = 20,
   parameter int   P_CNT_W      = 5,
   parameter logic P_ACTIVE_LOW = 1'b0
`ifdef BUTTON_DEBOUNCER_REPEAT_EN
   ,
   parameter int   P_REPEAT_DLY = 500,
   parameter int   P_REPEAT_PER = 100,
   parameter int   P_REP_W      = 10
`endif
) (
   input  logic               I_CLK,
   input  logic               I_RST,
   button_debouncer_if.slave  bus
);

   localparam logic [P_CNT_W-1:0] CNT_LAST = P_CNT_W'(P_STABLE - 1);

   logic [P_CH-1:0]    btn_pol;
   logic [P_CH-1:0]    sync1_q;
   logic [P_CH-1:0]    sync2_q;
   logic [P_CNT_W-1:0] cnt_q [P_CH];
   logic [P_CNT_W-1:0] cnt_d [P_CH];
   logic [P_CH-1:0]    level_q, level_d;
   logic [P_CH-1:0]    press_q, press_d;
   logic [P_CH-1:0]    rel_q, rel_d;

   // Polarity is normalised before the synchroniser so everything downstream sees 1 = pressed.
   assign btn_pol = P_ACTIVE_LOW ? ~bus.I_BTN : bus.I_BTN;

   // Two-flop synchroniser runs every clock and ignores CE, so sampled data is always settled.
   always_ff @(posedge I_CLK) begin
      if (I_RST) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= btn_pol;
         sync2_q <= sync1_q;
      end
   end

   // Stable-count filter: any sample equal to the current level restarts the count. The new level is taken on the last count.
   always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      press_d = '0;
      rel_d   = '0;
      if (bus.I_CE) begin
         for (int i = 0; i < P_CH; i++) begin
            if (sync2_q[i] == level_q[i]) begin
               cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
               cnt_d[i]   = '0;
               level_d[i] = sync2_q[i];
               press_d[i] = sync2_q[i];
               rel_d[i]   = ~sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + P_CNT_W'(1);
            end
         end
      end
   end

   // Filter state and strobes. A strobe is registered with its level change and cleared on the next clock.
   always_ff @(posedge I_CLK) begin
      if (I_RST) begin
         for (int i = 0; i < P_CH; i++) begin
            cnt_q[i] <= '0;
         end
         level_q <= '0;
         press_q <= '0;
         rel_q   <= '0;
      end else begin
         cnt_q   <= cnt_d;
         level_q <= level_d;
         press_q <= press_d;
         rel_q   <= rel_d;
      end
   end

   assign bus.O_LEVEL   = level_q;
   assign bus.O_PRESS   = press_q;
   assign bus.O_RELEASE = rel_q;

`ifdef BUTTON_DEBOUNCER_REPEAT_EN
   localparam logic [P_REP_W-1:0] DLY_LAST = P_REP_W'(P_REPEAT_DLY - 1);
   localparam logic [P_REP_W-1:0] PER_LAST = P_REP_W'(P_REPEAT_PER - 1);

   logic [P_REP_W-1:0] rep_cnt_q [P_CH];
   logic [P_REP_W-1:0] rep_cnt_d [P_CH];
   // rep_phase_q: 0 while waiting out the initial delay, 1 once periodic repeats have started.
   logic [P_CH-1:0]    rep_phase_q, rep_phase_d;
   logic [P_CH-1:0]    rep_q, rep_d;

   // Auto-repeat: restarted by a press, held at zero while released, counts CE ticks while held.
   always_comb begin
      rep_cnt_d   = rep_cnt_q;
      rep_phase_d = rep_phase_q;
      rep_d       = '0;
      for (int i = 0; i < P_CH; i++) begin
         if (!level_d[i] || press_d[i]) begin
            rep_cnt_d[i]   = '0;
            rep_phase_d[i] = 1'b0;
         end else if (bus.I_CE) begin
            if (rep_cnt_q[i] == (rep_phase_q[i] ? PER_LAST : DLY_LAST)) begin
               rep_d[i]       = 1'b1;
               rep_cnt_d[i]   = '0;
               rep_phase_d[i] = 1'b1;
            end else begin
               rep_cnt_d[i] = rep_cnt_q[i] + P_REP_W'(1);
            end
         end
      end
   end

   // Repeat counters and the one-clock repeat strobe.
   always_ff @(posedge I_CLK) begin
      if (I_RST) begin
         for (int i = 0; i < P_CH; i++) begin
            rep_cnt_q[i] <= '0;
         end
         rep_phase_q <= '0;
         rep_q       <= '0;
      end else begin
         rep_cnt_q   <= rep_cnt_d;
         rep_phase_q <= rep_phase_d;
         rep_q       <= rep_d;
      end
   end

   assign bus.O_REPEAT = rep_q;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: scoreboard bench for button_debouncer with P_STABLE=4 and CE every 10 clocks.
// Expected strobes (kind, channel mask, CE index) are queued when stimulus is driven and compared as they appear.
// Level and reset values are checked directly at CE boundaries.
module tb_button_debouncer;
   localparam int CH      = 4;
   localparam int STABLE  = 4;
   localparam int CE_PER  = 10;
   localparam int REP_DLY = 8;
   localparam int REP_PER = 3;

   localparam logic [1:0] K_PRESS   = 2'd1;
   localparam logic [1:0] K_RELEASE = 2'd2;
   localparam logic [1:0] K_REPEAT  = 2'd3;

   typedef struct packed {
      logic [1:0]  kind;
      logic [3:0]  mask;
      logic [31:0] ce_at;
   } ev_t;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   int   ce_idx   = 0;
   ev_t  sb_q[$];

   button_debouncer_if #(.P_CH(CH)) bus_if ();

   button_debouncer #(
      .P_CH        (CH),
      .P_STABLE    (STABLE),
      .P_CNT_W     (3),
      .P_ACTIVE_LOW(1'b0)
`ifdef BUTTON_DEBOUNCER_REPEAT_EN
      ,
      .P_REPEAT_DLY(REP_DLY),
      .P_REPEAT_PER(REP_PER),
      .P_REP_W     (4)
`endif
   ) dut (
      .I_CLK(clk),
      .I_RST(rst),
      .bus  (bus_if)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push_ev(input logic [1:0] kind, input logic [3:0] mask, input int at);
      ev_t e;
      e.kind  = kind;
      e.mask  = mask;
      e.ce_at = at;
      sb_q.push_back(e);
   endtask

   task automatic sb_cmp(input logic [1:0] kind, input logic [3:0] mask);
      ev_t e;
      if (sb_q.size() == 0) begin
         chk("unexpected_strobe", {kind, mask, ce_idx}, 64'd0);
      end else begin
         e = sb_q.pop_front();
         chk("strobe", {kind, mask, ce_idx}, {e.kind, e.mask, e.ce_at});
      end
   endtask

   // CE generator: one-clock pulse every CE_PER clocks.
   initial begin
      bus_if.I_CE = 1'b0;
      forever begin
         repeat (CE_PER - 1) @(posedge clk);
         #1 bus_if.I_CE = 1'b1;
         @(posedge clk);
         #1 bus_if.I_CE = 1'b0;
      end
   end

   // Count the CE edges the DUT has seen.
   always @(posedge clk) begin
      if (bus_if.I_CE) ce_idx <= ce_idx + 1;
   end

   // Strobe monitor on the falling edge.
   always @(negedge clk) begin
      if (bus_if.O_PRESS != '0)   sb_cmp(K_PRESS, bus_if.O_PRESS);
      if (bus_if.O_RELEASE != '0) sb_cmp(K_RELEASE, bus_if.O_RELEASE);
`ifdef BUTTON_DEBOUNCER_REPEAT_EN
      if (bus_if.O_REPEAT != '0)  sb_cmp(K_REPEAT, bus_if.O_REPEAT);
`endif
   end

   task automatic wait_ce();
      int n = 0;
      do begin
         @(posedge clk);
         n++;
      end while (!bus_if.I_CE && n < 4 * CE_PER);
      if (!bus_if.I_CE) chk("ce_timeout", 64'd1, 64'd0);
      #1;
   endtask

   task automatic wait_n_ce(input int n);
      for (int k = 0; k < n; k++) wait_ce();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      int p;
      rst          = 1'b1;
      bus_if.I_BTN = 4'b1111;

      // Reset held for 3 clocks with all buttons pressed.
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         chk("reset_outputs", {bus_if.O_LEVEL, bus_if.O_PRESS, bus_if.O_RELEASE}, 64'd0);
      end
      rst = 1'b0;
      push_ev(K_PRESS, 4'b1111, ce_idx + STABLE);
      for (int k = 0; k < STABLE - 1; k++) begin
         wait_ce();
         chk("post_reset_level", bus_if.O_LEVEL, 64'd0);
      end
      wait_ce();
      chk("post_reset_accept", bus_if.O_LEVEL, 64'hF);
      bus_if.I_BTN = 4'b0000;
      push_ev(K_RELEASE, 4'b1111, ce_idx + STABLE);
      wait_n_ce(STABLE);
      chk("all_released", bus_if.O_LEVEL, 64'd0);

      // Clean press and release on channel 0.
      wait_n_ce(2);
      bus_if.I_BTN = 4'b0001;
      push_ev(K_PRESS, 4'b0001, ce_idx + STABLE);
      for (int k = 0; k < STABLE - 1; k++) begin
         wait_ce();
         chk("clean_early", bus_if.O_LEVEL, 64'd0);
      end
      wait_ce();
      chk("clean_accept", bus_if.O_LEVEL, 64'h1);
      bus_if.I_BTN = 4'b0000;
      push_ev(K_RELEASE, 4'b0001, ce_idx + STABLE);
      wait_n_ce(STABLE);
      chk("clean_release", bus_if.O_LEVEL, 64'd0);

      // Bounce on channel 1: each value lasts 2 samples, never long enough.
      for (int k = 0; k < 10; k++) begin
         bus_if.I_BTN[1] = (k % 2 == 0);
         wait_n_ce(2);
      end
      bus_if.I_BTN[1] = 1'b0;
      wait_n_ce(STABLE);
      chk("bounce_level", bus_if.O_LEVEL, 64'd0);
      bus_if.I_BTN[1] = 1'b1;
      push_ev(K_PRESS, 4'b0010, ce_idx + STABLE);
      wait_n_ce(STABLE - 1);
      chk("bounce_hold3", bus_if.O_LEVEL, 64'd0);
      wait_ce();
      chk("bounce_hold4", bus_if.O_LEVEL, 64'h2);
      bus_if.I_BTN[1] = 1'b0;
      push_ev(K_RELEASE, 4'b0010, ce_idx + STABLE);
      wait_n_ce(STABLE);
      chk("bounce_release", bus_if.O_LEVEL, 64'd0);

      // Channels 0 and 2 pressed and released together.
      bus_if.I_BTN = 4'b0101;
      push_ev(K_PRESS, 4'b0101, ce_idx + STABLE);
      wait_n_ce(STABLE);
      chk("simul_press", bus_if.O_LEVEL, 64'h5);
      bus_if.I_BTN = 4'b0000;
      push_ev(K_RELEASE, 4'b0101, ce_idx + STABLE);
      wait_n_ce(STABLE);
      chk("simul_release", bus_if.O_LEVEL, 64'd0);

      // Reset in the middle of a count on channel 3.
      bus_if.I_BTN = 4'b1000;
      wait_n_ce(2);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_mid_outputs", {bus_if.O_LEVEL, bus_if.O_PRESS, bus_if.O_RELEASE}, 64'd0);
      push_ev(K_PRESS, 4'b1000, ce_idx + STABLE);
      wait_n_ce(2);
      chk("rst_mid_no_press", bus_if.O_LEVEL, 64'd0);
      wait_n_ce(STABLE - 2);
      chk("rst_mid_accept", bus_if.O_LEVEL, 64'h8);
      bus_if.I_BTN = 4'b0000;
      push_ev(K_RELEASE, 4'b1000, ce_idx + STABLE);
      wait_n_ce(STABLE);
      chk("rst_mid_release", bus_if.O_LEVEL, 64'd0);

`ifdef BUTTON_DEBOUNCER_REPEAT_EN
      // Auto-repeat on channel 0: first at press+8, then every 3 ticks until release at press+18.
      bus_if.I_BTN = 4'b0001;
      p = ce_idx + STABLE;
      push_ev(K_PRESS, 4'b0001, p);
      for (int t = REP_DLY; t < 18; t += REP_PER) push_ev(K_REPEAT, 4'b0001, p + t);
      wait_n_ce(STABLE + 14);
      chk("repeat_level", bus_if.O_LEVEL, 64'h1);
      bus_if.I_BTN = 4'b0000;
      push_ev(K_RELEASE, 4'b0001, ce_idx + STABLE);
      wait_n_ce(14);
      chk("repeat_released", bus_if.O_LEVEL, 64'd0);
`else
      p = 0;
`endif

      wait_n_ce(2);
      chk("sb_empty", sb_q.size(), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Multi-channel push-button/switch debouncer that consumes the 1 kHz clock-enable tick from the team's clock enable generator.
- Synchronises raw board inputs into I_CLK and filters bounce by requiring P_STABLE consecutive CE samples at a new value.
- Publishes a clean level per channel plus single-cycle press/release strobes for downstream control FSMs.

Parameters:
- P_CH, 4: number of independent button channels.
- P_STABLE, 20: consecutive CE samples required to accept a new level (20 ms at 1 kHz); legal range >= 1.
- P_CNT_W, 5: stable-counter width; must hold P_STABLE-1.
- P_ACTIVE_LOW, 1'b0: 1 = inputs are active-low and are inverted before the synchroniser.
- P_REPEAT_DLY, 500: CE ticks from press to first repeat strobe (optional feature only).
- P_REPEAT_PER, 100: CE ticks between subsequent repeat strobes (optional feature only).
- P_REP_W, 10: repeat-counter width; must hold max(P_REPEAT_DLY, P_REPEAT_PER)-1.

Ports:
- I_CLK  in  1  system clock.
- I_RST  in  1  reset: synchronous, active-high; clock I_CLK.
- I_CE  in  1  sample enable, one I_CLK wide, typically 1 kHz.
- I_BTN  in  P_CH  raw asynchronous button inputs.
- O_LEVEL  out  P_CH  debounced level, 1 = pressed.
- O_PRESS  out  P_CH  one-cycle strobe on accepted 0->1.
- O_RELEASE  out  P_CH  one-cycle strobe on accepted 1->0.
- O_REPEAT  out  P_CH  one-cycle auto-repeat strobe; present only with the optional feature.

Behaviour:
- Polarity: inversion (P_ACTIVE_LOW = 1) is applied combinationally ahead of the synchroniser.
- Synchroniser: 2-FF per channel, clocked every I_CLK, independent of I_CE.
- Reset: synchroniser regs, counters, O_LEVEL, O_PRESS, O_RELEASE and O_REPEAT all go to 0.
- Per channel, on a cycle with I_CE=1:
  - If sync bit == O_LEVEL: cnt <= 0. Any bounce back to the current level restarts the count.
  - Else if cnt == P_STABLE-1: O_LEVEL <= sync bit; cnt <= 0; O_PRESS or O_RELEASE <= 1 for that channel.
  - Else: cnt <= cnt+1.
- I_CE=0: counters and level hold.
- Strobes are registered in the same edge as the O_LEVEL change and forced to 0 on the next I_CLK, regardless of I_CE.
- Latency: a clean edge is accepted on the P_STABLE-th CE sample that sees the new value. Total latency is 2 I_CLK of synchronisation plus P_STABLE CE periods, depending on CE phase.
- P_STABLE=1: accepted on the first differing CE sample.
- Counter never exceeds P_STABLE-1; no wrap.
- Channels are fully independent; simultaneous acceptance on several channels strobes all of them in the same cycle.
- I_RST mid-count: count discarded, level 0, no strobes emitted on or after the reset cycle. A button held through reset is re-accepted as a fresh press after P_STABLE CE samples.
- Constant input equal to level: no activity.

Optional Feature:
- Macro BUTTON_DEBOUNCER_REPEAT_EN.
- Defined:
  - Adds the O_REPEAT port and a per-channel P_REP_W repeat counter.
  - Counter clears on the O_PRESS cycle and increments on each CE while O_LEVEL=1.
  - On reaching P_REPEAT_DLY-1 it pulses O_REPEAT for one I_CLK. Thereafter it pulses every P_REPEAT_PER CE ticks until release.
  - On release, or when O_LEVEL=0, the counter clears and no strobes are emitted.
- Undefined: O_REPEAT port and repeat logic are absent; P_REPEAT_* and P_REP_W are ignored.

Test Plan:
- Reset: assert I_RST 3 cycles with I_BTN=4'b1111 -> all outputs 0 during and after reset until 4 CE samples.
- Clean press: P_STABLE=4, CE every 10 clk; I_BTN[0] 0->1 held -> O_LEVEL[0]=1 on the 4th CE after sync; O_PRESS[0] high exactly 1 clk; other channels quiet.
- Bounce: I_BTN[1] toggles every 2 CE ticks for 20 ticks, then 0 -> no O_LEVEL change and no strobes; then held 1 for 3 ticks -> still 0; 4th tick -> accepted.
- Release and simultaneity: hold channels 0 and 2, then release both in the same cycle -> O_RELEASE=4'b0101 in one cycle, O_LEVEL returns 0.
- Reset mid-count: I_BTN[3]=1, pulse I_RST after 2 CE samples -> no press after 2 more samples; accepted after 4 samples post-reset.
- BUTTON_DEBOUNCER_REPEAT_EN with P_REPEAT_DLY=8, P_REPEAT_PER=3: hold I_BTN[0] -> O_REPEAT[0] pulses at CE 8, 11, 14 after press; release -> no further pulses.
